demux_striping_nlane: RTL and testbench
=======================================

// Module: demux_striping_nlane
// PURPOSE
// - Parametrised successor to the 2-lane striper: distributes a 32-bit (DATA_W) word stream round-robin over NUM_LANES lanes.
// - Each lane has a DEPTH-entry FIFO with its own valid/ready handshake, so lanes drain independently.
// - A runtime lane-enable mask sets link width (x1/x2/x4...). Sits between the TX byte/word source and the per-lane serializers.
// - Single clock domain. Replaces the fixed clk_f/clk_2f two-lane scheme.
// PARAMETERS
// DATA_W     32  width of one word / one lane
// NUM_LANES   4  number of output lanes, >=2
// DEPTH       4  per-lane FIFO entries, power of 2, >=2
// PORTS
// clk_2f      in   1               single clock, all logic on posedge
// reset_L     in   1               asynchronous, active-low reset
// data_input  in   DATA_W          input word
// valid_in    in   1               data_input is valid
// ready_out   out  1               block accepts data_input this cycle
// lane_en     in   NUM_LANES       lane-enable mask, loaded on realign
// realign     in   1               load lane_en, restart round-robin
// lane_data   out  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
// lane_valid  out  NUM_LANES       lane i FIFO non-empty
// lane_ready  in   NUM_LANES       lane i consumer takes head word
// active_mask out  NUM_LANES       currently applied lane mask
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - All FIFOs empty; lane_valid=0; lane_data=0.
//   - Pointer = lane 0; active_mask = all ones; ready_out=0 while reset_L=0.
// - Accept: a word is accepted when valid_in && ready_out on a clk_2f edge.
//   - ready_out = !realign && !full[ptr].
//   - The word is written to FIFO[ptr].
//   - ptr advances to the next enabled lane above ptr, wrapping to the lowest enabled lane.
// - Latency: a word accepted at edge t appears at edge t+1 on lane_data[ptr] with lane_valid=1, if that FIFO was empty.
//   - FIFOs are show-ahead; lane_data shows the head entry.
//   - lane_data is 0 for an empty lane.
// - Pop: lane i pops on lane_valid[i] && lane_ready[i]. lane_ready is ignored when the FIFO is empty.
// - Full FIFO: ready_out depends on full only, with no push-through.
//   - A simultaneous pop on a full target lane still blocks the push that cycle.
//   - The stream stalls; no other lane is skipped to.
// - Push+pop on the same non-full FIFO in one cycle: both occur and the count is unchanged.
// - Realign cycle:
//   - ready_out=0; no word accepted.
//   - active_mask <= lane_en, or 1 (lane 0 only) if lane_en==0.
//   - ptr <= lowest set bit of the new mask.
//   - FIFOs are not flushed; pops continue.
// - Disabled lanes are never pushed. Their residual FIFO contents still drain via lane_ready.
// - Wrap-around: FIFO pointers are log2(DEPTH) bits plus 1 wrap bit.
//   - full = same index with different wrap bit; empty = identical.
// - Reset mid-operation: all FIFO contents are discarded immediately; state returns to reset values.
// TESTING
// - T1 basic stripe, mask 4'b1111, all lane_ready=1:
//   - Send A0..A7 back-to-back.
//   - Lane0 gets A0 then A4, lane1 A1 then A5, lane2 A2 then A6, lane3 A3 then A7.
//   - Each word appears one cycle after acceptance.
// - T2 x2 width:
//   - realign with lane_en=4'b0101, then send 11111111,22222222,33333333.
//   - Lane0 gets 11111111 then 33333333; lane2 gets 22222222.
//   - Lanes 1 and 3 stay lane_valid=0.
// - T3 backpressure:
//   - lane_ready[1]=0, send 16 words with DEPTH=4.
//   - ready_out drops when ptr=1 and FIFO1 holds 4 words.
//   - Raise lane_ready[1]: the stream resumes with no loss, duplication or reordering.
// - T4 full + pop same cycle:
//   - FIFO1 full, ptr=1, lane_ready[1]=1, valid_in=1.
//   - That cycle: pop only, ready_out=0.
//   - Next cycle: push accepted.
// - T5 edge cases:
//   - realign with lane_en=0 -> active_mask=4'b0001; all words go to lane0.
//   - Assert realign concurrently with valid_in -> the word is not accepted.
// - T6 async reset:
//   - Drop reset_L between edges with 3 words buffered.
//   - lane_valid=0 and lane_data=0 immediately.
//   - After release, the first word goes to lane0.

Source files
------------

// File: rtl/demux_striping_nlane_if.sv
`default_nettype none
// ============================================================================
// Module  : demux_striping_nlane_if
// Brief   : Source-side word port and per-lane output handshakes of the striper.
// Revision: 1.0 - initial release
// ============================================================================
interface demux_striping_nlane_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4
);
    logic [DATA_W-1:0]           data_input;
    logic                        valid_in;
    logic                        ready_out;
    logic [NUM_LANES-1:0]        lane_en;
    logic                        realign;
    logic [NUM_LANES*DATA_W-1:0] lane_data;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES-1:0]        lane_ready;
    logic [NUM_LANES-1:0]        active_mask;

    modport master (
        output data_input, valid_in, lane_en, realign, lane_ready,
        input  ready_out, lane_data, lane_valid, active_mask
    );

    modport slave (
        input  data_input, valid_in, lane_en, realign, lane_ready,
        output ready_out, lane_data, lane_valid, active_mask
    );
endinterface
`default_nettype wire

// File: rtl/demux_striping_nlane.sv
`default_nettype none
// ============================================================================
// Module  : demux_striping_nlane
// Brief   : Round-robin word striper over NUM_LANES lanes, each with a
//           show-ahead DEPTH-entry FIFO and a runtime lane-enable mask.
// Revision: 1.0 - initial release
// ============================================================================
module demux_striping_nlane #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 4
) (
    input  wire logic              clk_2f,
    input  wire logic              reset_L,
    demux_striping_nlane_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = $clog2(NUM_LANES);

    logic [c_PW-1:0]      r_ptr;
    logic [c_PW-1:0]      w_next_ptr;
    logic [c_PW-1:0]      w_first_ptr;
    logic [c_PW-1:0]      w_idx;
    logic [NUM_LANES-1:0] r_mask;
    logic [NUM_LANES-1:0] w_new_mask;
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_push_lane;
    logic                 w_push;

    // Push is gated purely by the target lane's full flag: no push-through on a
    // same-cycle pop, and no skipping to another lane.
    assign bus.ready_out   = reset_L && !bus.realign && !w_full[r_ptr];
    assign w_push          = bus.valid_in && bus.ready_out;
    assign bus.active_mask = r_mask;

    always_comb begin
        w_new_mask = bus.lane_en;
        if (bus.lane_en == '0) begin
            w_new_mask = {{(NUM_LANES-1){1'b0}}, 1'b1};
        end
    end

    // Descending scan so the nearest enabled lane above r_ptr wins.
    always_comb begin
        w_next_ptr = r_ptr;
        w_idx      = '0;
        for (int k = NUM_LANES - 1; k >= 1; k--) begin
            w_idx = c_PW'((int'(r_ptr) + k) % NUM_LANES);
            if (r_mask[w_idx]) begin
                w_next_ptr = w_idx;
            end
        end
    end

    always_comb begin
        w_first_ptr = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (w_new_mask[k]) begin
                w_first_ptr = c_PW'(k);
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr  <= '0;
            r_mask <= '1;
        end else if (bus.realign) begin
            r_mask <= w_new_mask;
            r_ptr  <= w_first_ptr;
        end else if (w_push) begin
            r_ptr  <= w_next_ptr;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [c_PW-1:0] c_IDX = c_PW'(i);

        logic [c_AW:0]       r_wr;
        logic [c_AW:0]       r_rd;
        logic [DATA_W-1:0]   r_mem [DEPTH];
        logic                w_pop;

        assign w_full[i]      = (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]) && (r_wr[c_AW] != r_rd[c_AW]);
        assign w_empty[i]     = (r_wr == r_rd);
        assign w_push_lane[i] = w_push && (r_ptr == c_IDX);
        assign w_pop          = !w_empty[i] && bus.lane_ready[i];

        assign bus.lane_valid[i]                = !w_empty[i];
        assign bus.lane_data[i*DATA_W +: DATA_W] = w_empty[i] ? '0 : r_mem[r_rd[c_AW-1:0]];

        always_ff @(posedge clk_2f or negedge reset_L) begin
            if (!reset_L) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push_lane[i]) begin
                    r_wr <= r_wr + (c_AW+1)'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + (c_AW+1)'(1);
                end
            end
        end

        // Storage needs no reset: contents are only visible while non-empty.
        always_ff @(posedge clk_2f) begin
            if (w_push_lane[i]) begin
                r_mem[r_wr[c_AW-1:0]] <= bus.data_input;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_demux_striping_nlane.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_striping_nlane
// Brief   : Directed stimulus with per-lane expected-word queues and a
//           free-running monitor that checks every lane pop.
// Revision: 1.0 - initial release
// ============================================================================
module tb_demux_striping_nlane;
    localparam int DATA_W = 32;
    localparam int NL     = 4;
    localparam int DEPTH  = 4;

    logic clk_2f  = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk_2f = ~clk_2f;

    demux_striping_nlane_if #(.DATA_W(DATA_W), .NUM_LANES(NL)) bus ();

    demux_striping_nlane #(.DATA_W(DATA_W), .NUM_LANES(NL), .DEPTH(DEPTH)) dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [NL][$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a pop happens on the next edge wherever valid && ready.
    always @(negedge clk_2f) begin
        if (reset_L) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.lane_valid[i] && bus.lane_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("lane%0d unexpected word", i),
                              128'(bus.lane_data[i*DATA_W +: DATA_W]), 128'hFFFF_FFFF_FFFF);
                    end else begin
                        check($sformatf("lane%0d data", i),
                              128'(bus.lane_data[i*DATA_W +: DATA_W]), 128'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] w, input int lane);
        int budget;
        budget = 0;
        bus.valid_in   = 1'b1;
        bus.data_input = w;
        @(negedge clk_2f);
        while (!bus.ready_out && budget < 200) begin
            @(negedge clk_2f);
            budget++;
        end
        if (!bus.ready_out) begin
            check("send timeout", 128'(bus.ready_out), 128'd1);
        end else begin
            exp_q[lane].push_back(w);
        end
        @(posedge clk_2f); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic check_head(input string nm, input int lane, input logic [DATA_W-1:0] w);
        check({nm, " valid"}, 128'(bus.lane_valid[lane]), 128'd1);
        check({nm, " data"},  128'(bus.lane_data[lane*DATA_W +: DATA_W]), 128'(w));
    endtask

    task automatic do_realign(input logic [NL-1:0] en, input logic [NL-1:0] exp_mask);
        bus.realign    = 1'b1;
        bus.lane_en    = en;
        bus.valid_in   = 1'b1;
        bus.data_input = 32'hDEAD_BEEF;
        @(negedge clk_2f);
        check("realign ready_out", 128'(bus.ready_out), 128'd0);
        @(posedge clk_2f); #1;
        bus.realign  = 1'b0;
        bus.valid_in = 1'b0;
        check("realign active_mask", 128'(bus.active_mask), 128'(exp_mask));
    endtask

    task automatic drain(input string nm);
        int t;
        int left;
        t = 0;
        left = 1;
        while (left != 0 && t < 100) begin
            left = 0;
            for (int i = 0; i < NL; i++) left += exp_q[i].size();
            if (left != 0) begin
                @(posedge clk_2f); #1;
                t++;
            end
        end
        repeat (2) @(posedge clk_2f);
        #1;
        check({nm, " words left"}, 128'(left), 128'd0);
        check({nm, " lane_valid idle"}, 128'(bus.lane_valid), 128'd0);
        check({nm, " lane_data idle"}, bus.lane_data, 128'd0);
    endtask

    initial begin
        bus.data_input = '0;
        bus.valid_in   = 1'b0;
        bus.lane_en    = '1;
        bus.realign    = 1'b0;
        bus.lane_ready = '1;
        repeat (2) @(posedge clk_2f);
        #1;
        check("reset lane_valid", 128'(bus.lane_valid), 128'd0);
        check("reset lane_data", bus.lane_data, 128'd0);
        check("reset ready_out", 128'(bus.ready_out), 128'd0);
        check("reset active_mask", 128'(bus.active_mask), 128'hF);
        @(negedge clk_2f);
        reset_L = 1'b1;
        @(posedge clk_2f); #1;

        // T1: x4 striping, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            send(32'hA000_0000 + 32'(i), i % 4);
            check_head($sformatf("t1 latency A%0d", i), i % 4, 32'hA000_0000 + 32'(i));
        end
        drain("t1");

        // T2: x2 over lanes 0 and 2, concurrent valid word dropped
        do_realign(4'b0101, 4'b0101);
        send(32'h1111_1111, 0);
        send(32'h2222_2222, 2);
        check("t2 lanes1/3 idle", 128'(bus.lane_valid & 4'b1010), 128'd0);
        send(32'h3333_3333, 0);
        check("t2 lanes1/3 idle late", 128'(bus.lane_valid & 4'b1010), 128'd0);
        drain("t2");

        // T3: lane1 backpressure until its FIFO fills
        do_realign(4'b1111, 4'b1111);
        bus.lane_ready = 4'b1101;
        for (int i = 0; i < 17; i++) send(32'hB000_0000 + 32'(i), i % 4);
        bus.valid_in   = 1'b1;
        bus.data_input = 32'hB000_0011;
        repeat (3) @(posedge clk_2f);
        @(negedge clk_2f);
        check("t3 stall ready_out", 128'(bus.ready_out), 128'd0);
        check_head("t3 lane1 head", 1, 32'hB000_0001);
        @(posedge clk_2f); #1;

        // T4: pop on the full target lane does not admit the push that cycle
        bus.lane_ready = 4'b1111;
        @(negedge clk_2f);
        check("t4 full+pop ready_out", 128'(bus.ready_out), 128'd0);
        @(posedge clk_2f); #1;
        @(negedge clk_2f);
        check("t4 next ready_out", 128'(bus.ready_out), 128'd1);
        if (bus.ready_out) exp_q[1].push_back(32'hB000_0011);
        @(posedge clk_2f); #1;
        bus.valid_in = 1'b0;
        for (int i = 18; i < 24; i++) send(32'hB000_0000 + 32'(i), i % 4);
        drain("t3");

        // T5: empty enable mask falls back to lane 0 only
        do_realign(4'b0000, 4'b0001);
        for (int i = 0; i < 4; i++) send(32'hC000_0000 + 32'(i), 0);
        drain("t5");

        // T6: asynchronous reset with words buffered
        do_realign(4'b1111, 4'b1111);
        bus.lane_ready = '0;
        send(32'hE000_0000, 0);
        send(32'hE000_0001, 1);
        send(32'hE000_0002, 2);
        #3;
        reset_L = 1'b0;
        #1;
        check("t6 async lane_valid", 128'(bus.lane_valid), 128'd0);
        check("t6 async lane_data", bus.lane_data, 128'd0);
        check("t6 async ready_out", 128'(bus.ready_out), 128'd0);
        for (int i = 0; i < NL; i++) exp_q[i].delete();
        @(posedge clk_2f); #2;
        reset_L = 1'b1;
        bus.lane_ready = '1;
        @(posedge clk_2f); #1;
        check("t6 active_mask", 128'(bus.active_mask), 128'hF);
        send(32'hF000_0000, 0);
        check_head("t6 first word lane0", 0, 32'hF000_0000);
        send(32'hF000_0001, 1);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
